// File: rtl/onehot_scan_dec_if.sv
// onehot_scan_dec_if: control inputs and registered select outputs of the one-hot scan decoder
interface onehot_scan_dec_if #(parameter int AW = 3, parameter int DW = 16);
  logic en;
  logic mode;
  logic dir;
  logic [AW-1:0] a;
  logic [DW-1:0] dwell;
  logic [(1<<AW)-1:0] x;
  logic [AW-1:0] idx;
  logic wrap;
  modport master (output en, mode, dir, a, dwell, input x, idx, wrap);
  modport slave (input en, mode, dir, a, dwell, output x, idx, wrap);
endinterface

// File: rtl/onehot_scan_dec.sv
// onehot_scan_dec: registered binary-to-one-hot decoder with a self-running dwell-timed scan mode
module onehot_scan_dec #(
  parameter int AW = 3,
  parameter int DW = 16
) (
  input logic clk,
  input logic rst_n,
  onehot_scan_dec_if.slave bus
);
  localparam int N = 1 << AW;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [N-1:0] x_q, x_d;
  logic wrap_q, wrap_d, step;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    wrap_d = 1'b0;
    step = cnt_q >= bus.dwell;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == SCAN && bus.mode) begin
      cnt_d = step ? '0 : cnt_q + 1'b1;
      idx_d = step ? (bus.dir ? idx_q - 1'b1 : idx_q + 1'b1) : idx_q;
      // wrap edge is index N-1 going up, index 0 going down
      wrap_d = step && (idx_q == {AW{~bus.dir}});
    end else begin
      state_d = bus.mode ? SCAN : DIRECT;
      idx_d = bus.a;
      cnt_d = '0;
    end
    x_d = (state_d == IDLE) ? '0 : N'(1) << idx_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      x_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.x = x_q;
  assign bus.idx = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_onehot_scan_dec.sv
// tb_onehot_scan_dec: directed checks of reset, direct decode, up/down scan, live dwell and mid-scan exits
module tb_onehot_scan_dec;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int fails = 0;
  onehot_scan_dec_if #(.AW(3), .DW(16)) bus ();
  onehot_scan_dec #(.AW(3), .DW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [2:0] ei, input logic ew);
    chk({tag, ".idx"}, 32'(bus.idx), 32'(ei));
    chk({tag, ".x"}, 32'(bus.x), 32'(8'h01 << ei));
    chk({tag, ".wrap"}, 32'(bus.wrap), 32'(ew));
  endtask
  initial begin
    logic [2:0] up_idx [10];
    logic [2:0] dn_idx [4];
    up_idx = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};
    dn_idx = '{3'd1, 3'd0, 3'd7, 3'd6};
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.mode = 1'b1;
    bus.dir = 1'b0;
    bus.a = '0;
    bus.dwell = '0;
    // reset overrides en/mode
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.x", 32'(bus.x), 32'h0);
      chk("rst.idx", 32'(bus.idx), 32'h0);
      chk("rst.wrap", 32'(bus.wrap), 32'h0);
    end
    rst_n = 1'b1;
    tick();
    chk_out("rel", 3'd0, 1'b0);
    // direct sweep
    bus.mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.a = 3'(i);
      tick();
      chk_out("dir", 3'(i), 1'b0);
    end
    bus.a = 3'd0;
    tick();
    chk_out("dir_7to0", 3'd0, 1'b0);
    bus.en = 1'b0;
    tick();
    chk("blank.x", 32'(bus.x), 32'h0);
    chk("blank.wrap", 32'(bus.wrap), 32'h0);
    // scan up, dwell 2
    bus.en = 1'b1;
    bus.mode = 1'b1;
    bus.a = 3'd6;
    bus.dwell = 16'd2;
    bus.dir = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("up", up_idx[i], i == 6);
    end
    bus.en = 1'b0;
    tick();
    chk("idle.x", 32'(bus.x), 32'h0);
    // scan down, dwell 0
    bus.en = 1'b1;
    bus.a = 3'd1;
    bus.dwell = '0;
    bus.dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("down", dn_idx[i], i == 2);
    end
    // live dwell change
    bus.en = 1'b0;
    tick();
    bus.en = 1'b1;
    bus.a = 3'd2;
    bus.dwell = 16'd10;
    bus.dir = 1'b0;
    tick();
    chk_out("live0", 3'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("live_hold", 3'd2, 1'b0);
    end
    bus.dwell = 16'd1;
    tick();
    chk_out("live_step", 3'd3, 1'b0);
    tick();
    chk_out("live_h2", 3'd3, 1'b0);
    tick();
    chk_out("live_next", 3'd4, 1'b0);
    // mid-scan exits
    bus.mode = 1'b0;
    bus.a = 3'd3;
    tick();
    chk_out("mid_direct", 3'd3, 1'b0);
    bus.mode = 1'b1;
    bus.a = 3'd5;
    tick();
    chk_out("rescan", 3'd5, 1'b0);
    tick();
    chk_out("rescan_h", 3'd5, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst.x", 32'(bus.x), 32'h0);
    chk("mid_rst.idx", 32'(bus.idx), 32'h0);
    chk("mid_rst.wrap", 32'(bus.wrap), 32'h0);
    rst_n = 1'b1;
    bus.en = 1'b0;
    tick();
    chk("post.x", 32'(bus.x), 32'h0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
